mean_fifo_wr_ctrl: RTL and testbench

//   Write-side frame sequencer for the zone-mean -> LED FIFO in the local-dimming path.

---
 rtl/mean_fifo_pkg.sv | 24 ++
 rtl/mean_fifo_wr_ctrl_zone_grp_counter.sv | 68 ++++++
 rtl/mean_fifo_wr_ctrl.sv | 136 +++++++++++++
 tb/tb_mean_fifo_wr_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mean_fifo_pkg.sv
// Shared types and default geometry for the zone-mean -> LED FIFO write path.
package mean_fifo_pkg;

    localparam int unsigned DEF_DW        = 8;
    localparam int unsigned DEF_ZONES     = 40;
    localparam int unsigned DEF_GROUP_LEN = 42;
    localparam int unsigned DEF_ROWS      = 24;

    // Counter width for a modulo-n count; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned DEF_GRP_W = cnt_w(DEF_GROUP_LEN);
    localparam int unsigned DEF_ROW_W = cnt_w(DEF_ROWS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DROP    = 2'd2,
        DONE    = 2'd3
    } wr_state_t;

endpackage

// File: rtl/mean_fifo_wr_ctrl_zone_grp_counter.sv
// Byte-in-group and zone-row counters with position flags for the write sequencer.
module zone_grp_counter
    import mean_fifo_pkg::*;
#(
    parameter int unsigned ZONES     = DEF_ZONES,
    parameter int unsigned GROUP_LEN = DEF_GROUP_LEN,
    parameter int unsigned ROWS      = DEF_ROWS
) (
    input  logic                      wr_clk,
    input  logic                      rst_n,
    input  logic                      i_clear,
    input  logic                      i_active,
    input  logic                      i_valid,
    input  logic                      i_row_adv,
    output logic [cnt_w(ROWS)-1:0]    o_row_idx,
    output logic                      o_in_zone,
    output logic                      o_zone_last,
    output logic                      o_row_last,
    output logic                      o_mid_row
);

    localparam int unsigned GW = cnt_w(GROUP_LEN);
    localparam int unsigned RW = cnt_w(ROWS);

    localparam logic [GW-1:0] GRP_LAST  = GW'(GROUP_LEN - 1);
    localparam logic [GW-1:0] ZONE_N    = GW'(ZONES);
    localparam logic [GW-1:0] ZONE_LAST = GW'(ZONES - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);

    logic [GW-1:0] r_grp;
    logic [RW-1:0] r_row;
    logic [GW-1:0] w_grp_eff;
    logic [RW-1:0] w_row_eff;
    logic [GW-1:0] w_grp_nxt;
    logic [RW-1:0] w_row_nxt;

    // A clear presents position zero this cycle so a coincident byte lands at group slot 0.
    assign w_grp_eff = i_clear ? '0 : r_grp;
    assign w_row_eff = i_clear ? '0 : r_row;

    always_comb begin
        w_grp_nxt = '0;
        if (i_active && i_valid) begin
            w_grp_nxt = (w_grp_eff == GRP_LAST) ? '0 : w_grp_eff + 1'b1;
        end
        w_row_nxt = w_row_eff;
        if (i_row_adv) begin
            w_row_nxt = (w_row_eff == ROW_LAST) ? '0 : w_row_eff + 1'b1;
        end
    end

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grp <= '0;
            r_row <= '0;
        end else begin
            r_grp <= w_grp_nxt;
            r_row <= w_row_nxt;
        end
    end

    assign o_row_idx   = r_row;
    assign o_in_zone   = (w_grp_eff < ZONE_N);
    assign o_zone_last = (w_grp_eff == ZONE_LAST);
    assign o_row_last  = (w_row_eff == ROW_LAST);
    assign o_mid_row   = (w_grp_eff != '0) && o_in_zone;

endmodule

// File: rtl/mean_fifo_wr_ctrl.sv
// Write-side frame sequencer: frames zone-mean bytes into rows/frames and drives the LED FIFO.
module mean_fifo_wr_ctrl
    import mean_fifo_pkg::*;
#(
    parameter int unsigned DW        = DEF_DW,
    parameter int unsigned ZONES     = DEF_ZONES,
    parameter int unsigned GROUP_LEN = DEF_GROUP_LEN,
    parameter int unsigned ROWS      = DEF_ROWS
) (
    input  logic                   wr_clk,
    input  logic                   rst_n,
    input  logic                   frame_start,
    input  logic                   data_valid,
    input  logic [DW-1:0]          din,
    input  logic                   fifo_full,
    output logic                   fifo_wr_en,
    output logic [DW-1:0]          fifo_wr_data,
    output logic                   frame_done,
    output logic                   frame_tgl,
    output logic                   overflow_err,
    output logic                   line_err,
    output logic                   busy,
    output logic [cnt_w(ROWS)-1:0] row_idx
);

    wr_state_t r_state;
    wr_state_t w_state_nxt;

    logic          r_wr_en;
    logic [DW-1:0] r_wr_data;
    logic          r_done;
    logic          r_tgl;
    logic          r_ovf_err;
    logic          r_line_err;

    logic w_busy_st;
    logic w_collect;
    logic w_active;
    logic w_in_zone;
    logic w_zone_last;
    logic w_row_last;
    logic w_mid_row;
    logic w_wr_try;
    logic w_wr;
    logic w_ovf;
    logic w_row_adv;
    logic w_last;
    logic w_mid_drop;
    logic w_line_set;
    logic w_ovf_err_nxt;
    logic w_line_err_nxt;

    assign w_busy_st = (r_state == COLLECT) || (r_state == DROP);
    assign w_collect = frame_start || (r_state == COLLECT);
    assign w_active  = frame_start || w_busy_st;

    zone_grp_counter #(
        .ZONES     (ZONES),
        .GROUP_LEN (GROUP_LEN),
        .ROWS      (ROWS)
    ) u_cnt (
        .wr_clk      (wr_clk),
        .rst_n       (rst_n),
        .i_clear     (frame_start),
        .i_active    (w_active),
        .i_valid     (data_valid),
        .i_row_adv   (w_row_adv),
        .o_row_idx   (row_idx),
        .o_in_zone   (w_in_zone),
        .o_zone_last (w_zone_last),
        .o_row_last  (w_row_last),
        .o_mid_row   (w_mid_row)
    );

    assign w_wr_try   = w_collect && data_valid && w_in_zone;
    assign w_wr       = w_wr_try && !fifo_full;
    assign w_ovf      = w_wr_try && fifo_full;
    assign w_row_adv  = w_wr && w_zone_last;
    assign w_last     = w_row_adv && w_row_last;
    assign w_mid_drop = (r_state == COLLECT) && !frame_start && !data_valid && w_mid_row;
    assign w_line_set = (frame_start && w_busy_st) || w_mid_drop;

    // frame_start restarts collection, but an overflow or frame end on that same byte still applies.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = IDLE;
            COLLECT: w_state_nxt = COLLECT;
            DROP:    w_state_nxt = DROP;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (frame_start) begin
            w_state_nxt = COLLECT;
        end
        if (w_ovf) begin
            w_state_nxt = DROP;
        end else if (w_last) begin
            w_state_nxt = DONE;
        end

        w_ovf_err_nxt  = (frame_start ? 1'b0 : r_ovf_err) || w_ovf;
        w_line_err_nxt = (frame_start ? 1'b0 : r_line_err) || w_line_set;
    end

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_wr_en    <= 1'b0;
            r_wr_data  <= '0;
            r_done     <= 1'b0;
            r_tgl      <= 1'b0;
            r_ovf_err  <= 1'b0;
            r_line_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wr_en    <= w_wr;
            if (w_wr) begin
                r_wr_data <= din;
            end
            r_done     <= w_last;
            r_tgl      <= r_tgl ^ w_last;
            r_ovf_err  <= w_ovf_err_nxt;
            r_line_err <= w_line_err_nxt;
        end
    end

    assign fifo_wr_en   = r_wr_en;
    assign fifo_wr_data = r_wr_data;
    assign frame_done   = r_done;
    assign frame_tgl    = r_tgl;
    assign overflow_err = r_ovf_err;
    assign line_err     = r_line_err;
    assign busy         = w_busy_st;

endmodule

// File: tb/tb_mean_fifo_wr_ctrl.sv
// Scoreboard bench for mean_fifo_wr_ctrl: expected FIFO writes queued at drive time, popped at output.
module tb_mean_fifo_wr_ctrl;

    localparam int NZ = 40;
    localparam int GL = 42;
    localparam int NR = 24;

    logic       wr_clk = 1'b0;
    logic       rst_n;
    logic       frame_start;
    logic       data_valid;
    logic [7:0] din;
    logic       fifo_full;
    logic       fifo_wr_en;
    logic [7:0] fifo_wr_data;
    logic       frame_done;
    logic       frame_tgl;
    logic       overflow_err;
    logic       line_err;
    logic       busy;
    logic [4:0] row_idx;

    always #5 wr_clk = ~wr_clk;

    mean_fifo_wr_ctrl #(
        .DW        (8),
        .ZONES     (NZ),
        .GROUP_LEN (GL),
        .ROWS      (NR)
    ) dut (
        .wr_clk       (wr_clk),
        .rst_n        (rst_n),
        .frame_start  (frame_start),
        .data_valid   (data_valid),
        .din          (din),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .frame_done   (frame_done),
        .frame_tgl    (frame_tgl),
        .overflow_err (overflow_err),
        .line_err     (line_err),
        .busy         (busy),
        .row_idx      (row_idx)
    );

    typedef struct {
        logic [7:0] d;
        logic       done;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   vec_cnt  = 0;
    int   miss_cnt = 0;
    int   wr_cnt   = 0;
    int   done_cnt = 0;
    logic exp_tgl  = 1'b0;

    task automatic chk(input string tag, input int obs, input int exp);
        vec_cnt++;
        if (obs != exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input int row, input int i);
        return 8'(row * GL + i);
    endfunction

    always @(negedge wr_clk) begin
        if (fifo_wr_en) begin
            wr_cnt++;
            if (frame_done) done_cnt++;
            if (sb_q.size() == 0) begin
                chk("wr_unexpected", int'(fifo_wr_en), 0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("wr_data", int'(fifo_wr_data), int'(mon_e.d));
                chk("wr_done", int'(frame_done), int'(mon_e.done));
            end
        end else if (frame_done) begin
            done_cnt++;
            chk("done_without_wr", int'(frame_done), int'(fifo_wr_en));
        end
    end

    task automatic cyc(input logic fs, input logic dv, input logic [7:0] d, input logic full);
        frame_start = fs;
        data_valid  = dv;
        din         = d;
        fifo_full   = full;
        @(posedge wr_clk);
        #1;
        frame_start = 1'b0;
        data_valid  = 1'b0;
        fifo_full   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic push(input logic [7:0] d, input logic done);
        exp_t e;
        e.d    = d;
        e.done = done;
        sb_q.push_back(e);
    endtask

    // One 42-byte group; bytes 0..39 are expected in the FIFO when wr is set.
    task automatic send_row(input int row, input bit wr);
        for (int i = 0; i < GL; i++) begin
            if (wr && i < NZ) push(byte_of(row, i), (row == NR - 1) && (i == NZ - 1));
            cyc(1'b0, 1'b1, byte_of(row, i), 1'b0);
        end
    endtask

    task automatic clean_frame(input string tag);
        int w0;
        int d0;
        w0 = wr_cnt;
        d0 = done_cnt;
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        for (int r = 0; r < NR; r++) send_row(r, 1'b1);
        idle(3);
        exp_tgl = ~exp_tgl;
        chk({tag, "_writes"}, wr_cnt - w0, NR * NZ);
        chk({tag, "_done_cnt"}, done_cnt - d0, 1);
        chk({tag, "_tgl"}, int'(frame_tgl), int'(exp_tgl));
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int w0;
        int d0;

        rst_n       = 1'b0;
        frame_start = 1'b0;
        data_valid  = 1'b0;
        din         = 8'h00;
        fifo_full   = 1'b0;
        repeat (3) @(posedge wr_clk);
        #1;
        chk("rst_wr_en", int'(fifo_wr_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_row", int'(row_idx), 0);
        chk("rst_tgl", int'(frame_tgl), 0);
        chk("rst_errs", int'({overflow_err, line_err, frame_done}), 0);
        rst_n = 1'b1;
        idle(2);

        // Clean frames back-to-back: 960 writes each, tgl 0->1->0.
        clean_frame("clean1");
        chk("clean1_errs", int'({overflow_err, line_err}), 0);
        clean_frame("clean2");

        // Overflow at row 3 byte 5.
        w0 = wr_cnt;
        d0 = done_cnt;
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        for (int r = 0; r < NR; r++) begin
            for (int i = 0; i < GL; i++) begin
                if (i < NZ && (r < 3 || (r == 3 && i < 5))) push(byte_of(r, i), 1'b0);
                cyc(1'b0, 1'b1, byte_of(r, i), (r == 3 && i == 5) ? 1'b1 : 1'b0);
            end
        end
        idle(3);
        chk("ovf_writes", wr_cnt - w0, 125);
        chk("ovf_done_cnt", done_cnt - d0, 0);
        chk("ovf_err", int'(overflow_err), 1);
        chk("ovf_busy", int'(busy), 1);
        chk("ovf_tgl", int'(frame_tgl), int'(exp_tgl));
        // Restart from DROP: overflow clears, restart-while-busy flags line_err.
        w0 = wr_cnt;
        d0 = done_cnt;
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        chk("ovf_clear", int'(overflow_err), 0);
        chk("ovf_restart_line", int'(line_err), 1);
        chk("ovf_restart_row", int'(row_idx), 0);
        for (int r = 0; r < NR; r++) send_row(r, 1'b1);
        idle(3);
        exp_tgl = ~exp_tgl;
        chk("rec_writes", wr_cnt - w0, NR * NZ);
        chk("rec_done_cnt", done_cnt - d0, 1);
        chk("rec_ovf", int'(overflow_err), 0);

        // data_valid drop after 20 bytes of row 2, then fresh group.
        w0 = wr_cnt;
        d0 = done_cnt;
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        chk("mid_line_clr", int'(line_err), 0);
        send_row(0, 1'b1);
        send_row(1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            push(byte_of(2, i), 1'b0);
            cyc(1'b0, 1'b1, byte_of(2, i), 1'b0);
        end
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("mid_line_err", int'(line_err), 1);
        chk("mid_row_idx", int'(row_idx), 2);
        for (int r = 2; r < NR; r++) send_row(r, 1'b1);
        idle(3);
        exp_tgl = ~exp_tgl;
        chk("mid_writes", wr_cnt - w0, 2 * NZ + 20 + (NR - 2) * NZ);
        chk("mid_done_cnt", done_cnt - d0, 1);
        chk("mid_tgl", int'(frame_tgl), int'(exp_tgl));

        // frame_start mid row 10, carrying byte 0 of the new frame.
        w0 = wr_cnt;
        d0 = done_cnt;
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        for (int r = 0; r < 10; r++) send_row(r, 1'b1);
        for (int i = 0; i < 7; i++) begin
            push(byte_of(10, i), 1'b0);
            cyc(1'b0, 1'b1, byte_of(10, i), 1'b0);
        end
        push(byte_of(0, 0), 1'b0);
        cyc(1'b1, 1'b1, byte_of(0, 0), 1'b0);
        chk("rs_line_err", int'(line_err), 1);
        chk("rs_row_idx", int'(row_idx), 0);
        chk("rs_busy", int'(busy), 1);
        for (int i = 1; i < GL; i++) begin
            if (i < NZ) push(byte_of(0, i), 1'b0);
            cyc(1'b0, 1'b1, byte_of(0, i), 1'b0);
        end
        for (int r = 1; r < NR; r++) send_row(r, 1'b1);
        idle(3);
        exp_tgl = ~exp_tgl;
        chk("rs_writes", wr_cnt - w0, 10 * NZ + 7 + NR * NZ);
        chk("rs_done_cnt", done_cnt - d0, 1);
        chk("rs_tgl", int'(frame_tgl), int'(exp_tgl));

        // Asynchronous reset mid-row 5.
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        for (int r = 0; r < 5; r++) send_row(r, 1'b1);
        for (int i = 0; i < 10; i++) begin
            push(byte_of(5, i), 1'b0);
            cyc(1'b0, 1'b1, byte_of(5, i), 1'b0);
        end
        chk("pre_rst_busy", int'(busy), 1);
        chk("pre_rst_row", int'(row_idx), 5);
        @(negedge wr_clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_wr_en", int'(fifo_wr_en), 0);
        chk("arst_wr_data", int'(fifo_wr_data), 0);
        chk("arst_tgl", int'(frame_tgl), 0);
        chk("arst_errs", int'({overflow_err, line_err, frame_done}), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_row", int'(row_idx), 0);
        chk("arst_sb_empty", sb_q.size(), 0);
        @(posedge wr_clk);
        #1;
        rst_n = 1'b1;
        w0 = wr_cnt;
        for (int i = 0; i < 50; i++) cyc(1'b0, 1'b1, 8'(i), 1'b0);
        idle(3);
        chk("post_rst_writes", wr_cnt - w0, 0);
        chk("post_rst_busy", int'(busy), 0);

        chk("final_sb_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
